dcache_wb_buffer: RTL and testbench

- Single-entry write-back buffer on the D-cache side of the memory subsystem.
- Captures either an evicted dirty line or an uncached single-word store in one cycle.
- Drains the captured entry as one AXI write burst through the d_aw/d_w/d_b channels of the I/D arbiter, which forwards them to the outer bus unchanged.
- Gives the cache a combinational address-match check so a refill read never overtakes a pending write to the same line.

---
 rtl/dcache_wb_buffer.sv | 162 ++++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_buffer.sv
// Single-entry D-cache write-back buffer: captures an evicted dirty line or an
// uncached single-word store and drains it as one AXI write burst (AW, W, B).
// Also provides a combinational address-conflict check for pending refills.
module dcache_wb_buffer #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned OFFSET_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  // cache side
  input  logic                     wb_req,
  input  logic                     wb_single,
  input  logic [31:0]              wb_addr,
  input  logic [3:0]               wb_strb,
  input  logic [32*LINE_WORDS-1:0] wb_line,
  output logic                     wb_ready,
  output logic                     wb_busy,
  input  logic [31:0]              chk_addr,
  output logic                     chk_hit,
  // AXI write address channel
  output logic [31:0]              d_awaddr,
  output logic [7:0]               d_awlen,
  output logic [2:0]               d_awsize,
  output logic                     d_awvalid,
  input  logic                     d_awready,
  // AXI write data channel
  output logic [31:0]              d_wdata,
  output logic [3:0]               d_wstrb,
  output logic                     d_wlast,
  output logic                     d_wvalid,
  input  logic                     d_wready,
  // AXI write response channel
  input  logic                     d_bvalid,
  output logic                     d_bready
);

  localparam int unsigned IDX_W    = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam logic [7:0]  LINE_LEN = 8'(LINE_WORDS - 1);
  localparam logic [31:0] LINE_MSK = ~(32'((64'd1 << OFFSET_W) - 64'd1));
  localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [31:0]                    addr_q;
  logic                           single_q;
  logic [3:0]                     strb_q;
  logic [LINE_WORDS-1:0][31:0]    line_q;

  logic                           accept_c;
  logic [7:0]                     len_c;
  logic                           last_c;

  // Burst length and last-beat detect derived from the stored entry
  always_comb begin
    len_c  = single_q ? 8'd0 : LINE_LEN;
    last_c = (cnt_q == len_c[CNT_W-1:0]);
  end

  // State and beat-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and beat-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (wb_req) state_d = S_AW;
      end
      S_AW: begin
        if (d_awready) begin
          state_d = S_W;
          cnt_d   = '0;
        end
      end
      S_W: begin
        if (d_wready) begin
          if (last_c) state_d = S_B;
          else        cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_B: begin
        // a request accepted in the completion cycle skips IDLE entirely
        if (d_bvalid) state_d = wb_req ? S_AW : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry capture: latched on the accepting edge only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      single_q <= 1'b0;
      strb_q   <= '0;
      line_q   <= '0;
    end else if (accept_c) begin
      addr_q   <= wb_addr;
      single_q <= wb_single;
      strb_q   <= wb_strb;
      line_q   <= wb_line;
    end
  end

  // Output decode: channel fields are driven only while their valid is high
  always_comb begin
    d_awaddr  = '0;
    d_awlen   = '0;
    d_awsize  = '0;
    d_awvalid = 1'b0;
    d_wdata   = '0;
    d_wstrb   = '0;
    d_wlast   = 1'b0;
    d_wvalid  = 1'b0;
    d_bready  = 1'b0;
    case (state_q)
      S_AW: begin
        d_awvalid = 1'b1;
        d_awaddr  = addr_q;
        d_awlen   = len_c;
        d_awsize  = 3'b010;
      end
      S_W: begin
        d_wvalid = 1'b1;
        d_wdata  = line_q[cnt_q[IDX_W-1:0]];
        d_wstrb  = single_q ? strb_q : 4'hF;
        d_wlast  = last_c;
      end
      S_B: begin
        d_bready = 1'b1;
      end
      default: ;
    endcase
  end

  // Cache-side handshake, busy flag and refill hazard check
  always_comb begin
    wb_ready = (state_q == S_IDLE) | ((state_q == S_B) & d_bvalid);
    wb_busy  = (state_q != S_IDLE);
    accept_c = wb_req & wb_ready;
    // singles conflict at word granularity, lines at line granularity
    chk_hit  = wb_busy &
               (((chk_addr ^ addr_q) & (single_q ? WORD_MSK : LINE_MSK)) == 32'd0);
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: a per-cycle vector table for the
// basic line write, directed multi-cycle corner cases, and randomized traffic
// checked against a transaction-level model of the pending entry.
module tb_dcache_wb_buffer;

  localparam int unsigned LW = 8;
  localparam int unsigned OW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_req, wb_single;
  logic [31:0]       wb_addr;
  logic [3:0]        wb_strb;
  logic [32*LW-1:0]  wb_line;
  logic              wb_ready, wb_busy;
  logic [31:0]       chk_addr;
  logic              chk_hit;
  logic [31:0]       d_awaddr;
  logic [7:0]        d_awlen;
  logic [2:0]        d_awsize;
  logic              d_awvalid, d_awready;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_wlast, d_wvalid, d_wready;
  logic              d_bvalid, d_bready;

  dcache_wb_buffer #(.LINE_WORDS(LW), .OFFSET_W(OW)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_single(wb_single), .wb_addr(wb_addr),
    .wb_strb(wb_strb), .wb_line(wb_line),
    .wb_ready(wb_ready), .wb_busy(wb_busy),
    .chk_addr(chk_addr), .chk_hit(chk_hit),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize),
    .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bvalid(d_bvalid), .d_bready(d_bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // The pending entry, whether its address was taken, and how many data
  // beats have been handed over; everything else follows from these.
  bit          m_pend, m_aw_done, m_single;
  int          m_beats, m_n;
  logic [31:0] m_addr;
  logic [3:0]  m_strb;
  logic [31:0] m_line [LW];

  task automatic model_reset();
    m_pend = 0; m_aw_done = 0; m_beats = 0; m_n = 0;
  endtask

  task automatic drive(input logic req, input logic single, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [32*LW-1:0] line,
                       input logic awr, input logic wr, input logic bv,
                       input logic [31:0] ca);
    wb_req = req; wb_single = single; wb_addr = addr; wb_strb = strb; wb_line = line;
    d_awready = awr; d_wready = wr; d_bvalid = bv; chk_addr = ca;
  endtask

  // One clock: drive at negedge, compare 1 ns later, advance the model.
  task automatic step(input logic req, input logic single, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [32*LW-1:0] line,
                      input logic awr, input logic wr, input logic bv,
                      input logic [31:0] ca, output bit accepted);
    bit e_ready, e_awv, e_wv, e_bready, e_hit;
    logic [31:0] msk;
    @(negedge clk);
    drive(req, single, addr, strb, line, awr, wr, bv, ca);
    #1;
    e_awv    = m_pend && !m_aw_done;
    e_wv     = m_pend && m_aw_done && (m_beats < m_n);
    e_bready = m_pend && m_aw_done && (m_beats == m_n);
    e_ready  = !m_pend || (e_bready && bv);
    msk      = m_single ? 32'hFFFF_FFFC : 32'hFFFF_FFE0;
    e_hit    = m_pend && ((ca & msk) == (m_addr & msk));
    chk("wb_ready", 32'(wb_ready), 32'(e_ready));
    chk("wb_busy", 32'(wb_busy), 32'(m_pend));
    chk("awvalid", 32'(d_awvalid), 32'(e_awv));
    chk("wvalid", 32'(d_wvalid), 32'(e_wv));
    chk("bready", 32'(d_bready), 32'(e_bready));
    chk("chk_hit", 32'(chk_hit), 32'(e_hit));
    chk("aw_w_exclusive", 32'(d_awvalid & d_wvalid), 32'd0);
    if (e_awv) begin
      chk("awaddr", d_awaddr, m_addr);
      chk("awlen", 32'(d_awlen), 32'(m_n - 1));
      chk("awsize", 32'(d_awsize), 32'd2);
    end
    if (e_wv) begin
      chk("wdata", d_wdata, m_line[m_beats]);
      chk("wstrb", 32'(d_wstrb), m_single ? 32'(m_strb) : 32'hF);
      chk("wlast", 32'(d_wlast), 32'(m_beats == m_n - 1));
    end
    accepted = req && e_ready;
    if (accepted) begin
      m_pend = 1; m_aw_done = 0; m_beats = 0;
      m_single = single; m_addr = addr; m_strb = strb;
      m_n = single ? 1 : LW;
      for (int i = 0; i < LW; i++) m_line[i] = line[i*32 +: 32];
    end else begin
      if (e_bready && bv) m_pend = 0;
      if (e_awv && awr) m_aw_done = 1;
      if (e_wv && wr) m_beats++;
    end
  endtask

  // Let the pending entry finish with full-throughput handshakes.
  task automatic drain(input string tag);
    bit acc;
    int k;
    k = 0;
    while (m_pend && k < 60) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, '0, 1'b1, 1'b1,
           m_pend && m_aw_done && (m_beats == m_n), 32'h0, acc);
      k++;
    end
    if (m_pend) begin
      n_tests++; n_fail++;
      $display("FAIL %s_drain_timeout: entry still pending after %0d cycles", tag, k);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wb_ready"}, 32'(wb_ready), 32'd1);
    chk({tag, "_wb_busy"}, 32'(wb_busy), 32'd0);
    chk({tag, "_awvalid"}, 32'(d_awvalid), 32'd0);
    chk({tag, "_wvalid"}, 32'(d_wvalid), 32'd0);
    chk({tag, "_wlast"}, 32'(d_wlast), 32'd0);
    chk({tag, "_bready"}, 32'(d_bready), 32'd0);
    chk({tag, "_awaddr"}, d_awaddr, 32'd0);
    chk({tag, "_wdata"}, d_wdata, 32'd0);
    chk({tag, "_chk_hit"}, 32'(chk_hit), 32'd0);
  endtask

  // ---------------- vector table for the basic line write ----------------
  typedef struct {
    logic        req, awr, wr, bv;
    logic        e_ready, e_busy, e_awv, e_wv;
    logic [31:0] e_wdata;
    logic        e_wlast, e_bready, e_hit;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic awr, input logic wr, input logic bv,
                              input logic e_ready, input logic e_busy, input logic e_awv,
                              input logic e_wv, input logic [31:0] e_wdata, input logic e_wlast,
                              input logic e_bready, input logic e_hit);
    vec_t v;
    v.req = req; v.awr = awr; v.wr = wr; v.bv = bv;
    v.e_ready = e_ready; v.e_busy = e_busy; v.e_awv = e_awv; v.e_wv = e_wv;
    v.e_wdata = e_wdata; v.e_wlast = e_wlast; v.e_bready = e_bready; v.e_hit = e_hit;
    return v;
  endfunction

  localparam logic [31:0] LINE_A = 32'h1FC0_0040;

  initial begin
    vec_t             tbl [13];
    logic [32*LW-1:0] line_a, line_v;
    logic [31:0]      b2b_addr;
    bit               acc, req_act, r_single;
    logic [31:0]      r_addr;
    logic [3:0]       r_strb;
    logic [32*LW-1:0] r_line;
    int               k;

    // accept, AW, 8 beats, B without/with bvalid, back to IDLE
    tbl[0]  = mk(1, 1, 1, 0,  1, 0, 0, 0, 32'h0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0,  0, 1, 1, 0, 32'h0, 0, 0, 1);
    for (int b = 0; b < 8; b++)
      tbl[2+b] = mk(0, 1, 1, 0, 0, 1, 0, 1, 32'(17 * (b + 1)), (b == 7), 0, 1);
    tbl[10] = mk(0, 1, 1, 0,  0, 1, 0, 0, 32'h0, 0, 1, 1);
    tbl[11] = mk(0, 1, 1, 1,  1, 1, 0, 0, 32'h0, 0, 1, 1);
    tbl[12] = mk(0, 1, 1, 0,  1, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < LW; i++) line_a[i*32 +: 32] = 32'(17 * (i + 1));

    model_reset();
    drive(0, 0, 32'h0, 4'h0, '0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // table-driven line write
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].req, 1'b0, LINE_A, 4'h0, line_a, tbl[i].awr, tbl[i].wr, tbl[i].bv,
            32'h1FC0_0050);
      #1;
      chk($sformatf("tbl%0d_wb_ready", i), 32'(wb_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_wb_busy", i), 32'(wb_busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_awvalid", i), 32'(d_awvalid), 32'(tbl[i].e_awv));
      chk($sformatf("tbl%0d_wvalid", i), 32'(d_wvalid), 32'(tbl[i].e_wv));
      chk($sformatf("tbl%0d_bready", i), 32'(d_bready), 32'(tbl[i].e_bready));
      chk($sformatf("tbl%0d_chk_hit", i), 32'(chk_hit), 32'(tbl[i].e_hit));
      if (tbl[i].e_awv) begin
        chk($sformatf("tbl%0d_awaddr", i), d_awaddr, LINE_A);
        chk($sformatf("tbl%0d_awlen", i), 32'(d_awlen), 32'd7);
        chk($sformatf("tbl%0d_awsize", i), 32'(d_awsize), 32'd2);
      end
      if (tbl[i].e_wv) begin
        chk($sformatf("tbl%0d_wdata", i), d_wdata, tbl[i].e_wdata);
        chk($sformatf("tbl%0d_wstrb", i), 32'(d_wstrb), 32'hF);
        chk($sformatf("tbl%0d_wlast", i), 32'(d_wlast), 32'(tbl[i].e_wlast));
      end
    end

    // single uncached store
    line_v = '0;
    line_v[31:0] = 32'hDEAD_BEEF;
    step(1, 1, 32'hBFAF_8004, 4'b0011, line_v, 1, 1, 0, 32'h0, acc);
    chk("single_accept", 32'(acc), 32'd1);
    step(0, 0, 32'h0, 4'h0, '0, 1, 1, 0, 32'h0, acc);
    chk("single_awlen", 32'(d_awlen), 32'd0);
    step(0, 0, 32'h0, 4'h0, '0, 1, 1, 0, 32'h0, acc);
    chk("single_wstrb", 32'(d_wstrb), 32'h3);
    chk("single_wlast", 32'(d_wlast), 32'd1);
    drain("single");

    // hazard check and backpressure on line 0x1040
    for (int i = 0; i < LW; i++) line_v[i*32 +: 32] = $urandom;
    step(1, 0, 32'h0000_1040, 4'h0, line_v, 0, 0, 0, 32'h0, acc);
    for (int c = 0; c < 4; c++)
      step(0, 0, 32'h0, 4'h0, '0, 0, 0, 0, (c % 2 == 0) ? 32'h0000_105C : 32'h0000_1060, acc);
    chk("hz_awaddr_stalled", d_awaddr, 32'h0000_1040);
    chk("hz_miss_1060", 32'(chk_hit), 32'd0);
    step(0, 0, 32'h0, 4'h0, '0, 1, 0, 0, 32'h0000_105C, acc);
    chk("hz_hit_105c", 32'(chk_hit), 32'd1);
    k = 0;
    while (m_beats < m_n && k < 40) begin
      step(0, 0, 32'h0, 4'h0, '0, 0, 1'(k % 2 == 0), 0, 32'h0000_105C, acc);
      k++;
    end
    chk("bp_all_beats", 32'(m_beats), 32'(LW));
    step(0, 0, 32'h0, 4'h0, '0, 0, 0, 0, 32'h0000_105C, acc);
    step(0, 0, 32'h0, 4'h0, '0, 0, 0, 1, 32'h0000_105C, acc);
    step(0, 0, 32'h0, 4'h0, '0, 0, 0, 0, 32'h0000_105C, acc);
    chk("hz_clear_after_b", 32'(chk_hit), 32'd0);
    drain("hazard");

    // back-to-back: second request accepted in the bvalid cycle
    for (int i = 0; i < LW; i++) line_v[i*32 +: 32] = $urandom;
    step(1, 0, 32'h0000_2000, 4'h0, line_v, 1, 1, 0, 32'h0, acc);
    k = 0;
    while (!(m_aw_done && m_beats == m_n) && k < 20) begin
      step(0, 0, 32'h0, 4'h0, '0, 1, 1, 0, 32'h0, acc);
      k++;
    end
    b2b_addr = 32'h0000_3020;
    step(1, 1, b2b_addr, 4'hC, line_v, 1, 1, 1, 32'h0, acc);
    chk("b2b_accept", 32'(acc), 32'd1);
    step(0, 0, 32'h0, 4'h0, '0, 0, 0, 0, 32'h0, acc);
    chk("b2b_awvalid", 32'(d_awvalid), 32'd1);
    chk("b2b_awaddr", d_awaddr, b2b_addr);
    drain("b2b");

    // asynchronous reset in the middle of the data phase (beat 3)
    for (int i = 0; i < LW; i++) line_v[i*32 +: 32] = $urandom;
    step(1, 0, 32'h0000_4000, 4'h0, line_v, 1, 1, 0, 32'h0000_4000, acc);
    k = 0;
    while (m_beats < 3 && k < 20) begin
      step(0, 0, 32'h0, 4'h0, '0, 1, 1, 0, 32'h0000_4000, acc);
      k++;
    end
    @(negedge clk);
    drive(0, 0, 32'h0, 4'h0, '0, 1, 1, 0, 32'h0000_4000);
    #1;
    chk("mid_w_wvalid", 32'(d_wvalid), 32'd1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_mid_w");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < LW; i++) line_v[i*32 +: 32] = $urandom;
    step(1, 0, 32'h0000_5040, 4'h0, line_v, 1, 1, 0, 32'h0, acc);
    chk("post_rst_accept", 32'(acc), 32'd1);
    drain("post_rst");

    // randomized traffic against the model
    req_act = 0;
    r_single = 0; r_addr = '0; r_strb = '0; r_line = '0;
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] ca;
      bit awr, wr, bv;
      if (!req_act && ($urandom % 3 == 0)) begin
        req_act  = 1;
        r_single = 1'($urandom % 2);
        r_addr   = r_single ? ($urandom & 32'hFFFF_FFFC) : ($urandom & 32'hFFFF_FFE0);
        r_strb   = 4'($urandom % 15 + 1);
        for (int i = 0; i < LW; i++) r_line[i*32 +: 32] = $urandom;
      end
      awr = ($urandom % 4 != 0);
      wr  = ($urandom % 4 != 0);
      bv  = m_pend && m_aw_done && (m_beats == m_n) && ($urandom % 3 == 0);
      ca  = ($urandom % 2 == 1) ? (m_addr ^ 32'($urandom % 64)) : $urandom;
      step(req_act, r_single, r_addr, r_strb, r_line, awr, wr, bv, ca, acc);
      if (acc) req_act = 0;
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
